// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Drives PC, IR, register-file, ALU and shared single-port memory controls.
// Ports: clk, rst (sync, active high); opcode/funct/zero/mem_ready in;
//   state, pc_we, pc_src, ir_we, mem_re, mem_we, mem_addr_sel, alu_src,
//   alu_op, reg_we, reg_dst, mem_to_reg, instr_done, err out.
// Optional: define MC_CTRL_TIMEOUT_EN to trap on a mem_ready wait of MEM_TIMEOUT cycles.
module mips_mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit NOP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic       r_err;

    logic       w_pc_we;
    logic [1:0] w_pc_src;
    logic       w_ir_we;
    logic       w_mem_re;
    logic       w_mem_we;
    logic       w_mem_addr_sel;
    logic       w_alu_src;
    logic [1:0] w_alu_op;
    logic       w_reg_we;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_instr_done;

    // The ALU decodes funct straight from IR; the latched copy is kept
    // for datapath debug visibility only.
    logic       w_unused_funct;
    assign w_unused_funct = ^r_funct;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
    logic       w_waiting;
    assign w_waiting = (r_state == S_FETCH || r_state == S_MEM) && !mem_ready;
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_funct <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= opcode;
                r_funct <= funct;
            end
            if (w_next == S_TRAP)
                r_err <= 1'b1;
        end
    end

`ifdef MC_CTRL_TIMEOUT_EN
    // Any state change (including entry to FETCH/MEM) restarts the count.
    always_ff @(posedge clk) begin
        if (rst)
            r_wait_cnt <= '0;
        else if (w_next != r_state)
            r_wait_cnt <= '0;
        else if (w_waiting)
            r_wait_cnt <= r_wait_cnt + 8'd1;
    end
`endif

    always_comb begin
        w_next         = r_state;
        w_pc_we        = 1'b0;
        w_pc_src       = 2'b00;
        w_ir_we        = 1'b0;
        w_mem_re       = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_alu_src      = 1'b0;
        w_alu_op       = 2'b00;
        w_reg_we       = 1'b0;
        w_reg_dst      = 1'b0;
        w_mem_to_reg   = 1'b0;
        w_instr_done   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_re = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ:
                        w_next = S_EXEC;
                    OP_J: begin
                        w_pc_we      = 1'b1;
                        w_pc_src     = 2'b10;
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: begin
                        if (NOP_ILLEGAL) begin
                            w_instr_done = 1'b1;
                            w_next       = S_FETCH;
                        end else begin
                            w_next = S_TRAP;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                case (r_op)
                    OP_R: begin
                        w_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    OP_ADDI: begin
                        w_alu_src = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_SLTI: begin
                        w_alu_op  = 2'b11;
                        w_alu_src = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    OP_BEQ: begin
                        w_alu_op     = 2'b01;
                        w_pc_we      = zero;
                        w_pc_src     = zero ? 2'b01 : 2'b00;
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_addr_sel = 1'b1;
                w_alu_src      = 1'b1;
                if (r_op == OP_SW) begin
                    w_mem_we = 1'b1;
                    if (mem_ready) begin
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                end else begin
                    w_mem_re = 1'b1;
                    if (mem_ready)
                        w_next = S_WB;
                end
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = (r_op == OP_R);
                w_mem_to_reg = (r_op == OP_LW);
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
`ifdef MC_CTRL_TIMEOUT_EN
        // mem_ready in the limit cycle takes priority over the trap.
        if (w_waiting && r_wait_cnt == WAIT_LIM)
            w_next = S_TRAP;
`endif
    end

    // Strobes are gated by rst so a reset mid-access drops writes at once.
    assign state        = r_state;
    assign pc_we        = w_pc_we & ~rst;
    assign pc_src       = rst ? 2'b00 : w_pc_src;
    assign ir_we        = w_ir_we & ~rst;
    assign mem_re       = w_mem_re & ~rst;
    assign mem_we       = w_mem_we & ~rst;
    assign mem_addr_sel = w_mem_addr_sel & ~rst;
    assign alu_src      = w_alu_src & ~rst;
    assign alu_op       = rst ? 2'b00 : w_alu_op;
    assign reg_we       = w_reg_we & ~rst;
    assign reg_dst      = w_reg_dst & ~rst;
    assign mem_to_reg   = w_mem_to_reg & ~rst;
    assign instr_done   = w_instr_done & ~rst;
    assign err          = r_err;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for mips_mc_ctrl.
// Two instances: u_dut0 (NOP_ILLEGAL=1) and u_dut1 (NOP_ILLEGAL=0), lockstep inputs.
module tb_mips_mc_ctrl;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [2:0] st0, st1;
    logic       pcwe0, pcwe1;
    logic [1:0] pcs0, pcs1;
    logic       irwe0, irwe1, mre0, mre1, mwe0, mwe1;
    logic       mas0, mas1, asrc0, asrc1;
    logic [1:0] aop0, aop1;
    logic       rwe0, rwe1, rdst0, rdst1, m2r0, m2r1;
    logic       done0, done1, err0, err1;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_TIMEOUT(16), .NOP_ILLEGAL(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .state(st0),
        .pc_we(pcwe0), .pc_src(pcs0), .ir_we(irwe0), .mem_re(mre0),
        .mem_we(mwe0), .mem_addr_sel(mas0), .alu_src(asrc0),
        .alu_op(aop0), .reg_we(rwe0), .reg_dst(rdst0),
        .mem_to_reg(m2r0), .instr_done(done0), .err(err0)
    );

    mips_mc_ctrl #(.MEM_TIMEOUT(16), .NOP_ILLEGAL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .state(st1),
        .pc_we(pcwe1), .pc_src(pcs1), .ir_we(irwe1), .mem_re(mre1),
        .mem_we(mwe1), .mem_addr_sel(mas1), .alu_src(asrc1),
        .alu_op(aop1), .reg_we(rwe1), .reg_dst(rdst1),
        .mem_to_reg(m2r1), .instr_done(done1), .err(err1)
    );

    // {state,pc_we,pc_src,ir_we,mem_re,mem_we,mem_addr_sel,alu_src,
    //  alu_op,reg_we,reg_dst,mem_to_reg,instr_done,err}
    logic [17:0] v0, v1;
    assign v0 = {st0, pcwe0, pcs0, irwe0, mre0, mwe0, mas0, asrc0,
                 aop0, rwe0, rdst0, m2r0, done0, err0};
    assign v1 = {st1, pcwe1, pcs1, irwe1, mre1, mwe1, mas1, asrc1,
                 aop1, rwe1, rdst1, m2r1, done1, err1};

    typedef struct {
        bit          sel;
        string       tag;
        logic [17:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic check(input string tag, input logic [17:0] got,
                         input logic [17:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            check(e.tag, e.sel ? v1 : v0, e.exp);
        end
    end

    function automatic logic [17:0] ev(
        input logic [2:0] st, input logic pcwe, input logic [1:0] pcs,
        input logic irwe, input logic mre, input logic mwe,
        input logic mas, input logic asrc, input logic [1:0] aop,
        input logic rwe, input logic rdst, input logic m2r,
        input logic done, input logic er);
        return {st, pcwe, pcs, irwe, mre, mwe, mas, asrc,
                aop, rwe, rdst, m2r, done, er};
    endfunction

    // One clock: drive inputs, queue the expectation for each
    // selected instance, advance to just past the next edge.
    task automatic cyc(input logic r, input logic rdy, input logic z,
                       input bit c0, input logic [17:0] e0,
                       input bit c1, input logic [17:0] e1,
                       input string tag);
        sb_t s;
        rst = r;
        mem_ready = rdy;
        zero = z;
        if (c0) begin
            s.sel = 1'b0; s.tag = {tag, "/d0"}; s.exp = e0;
            sbq.push_back(s);
        end
        if (c1) begin
            s.sel = 1'b1; s.tag = {tag, "/d1"}; s.exp = e1;
            sbq.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic r, input logic rdy, input logic z,
                        input logic [17:0] e, input string tag);
        cyc(r, rdy, z, 1'b1, e, 1'b1, e, tag);
    endtask

    logic [17:0] Z0, F1, F0, DD, DJ, DNOP, EX_R, WB_R, EX_LS;
    logic [17:0] MEM_LW, WB_LW, MEM_SW, BEQ_T, BEQ_N;
    logic [17:0] EX_ADDI, EX_SLTI, WB_I, TRAPV, RST3;

    initial begin
        Z0      = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F1      = ev(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F0      = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DD      = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DJ      = ev(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        DNOP    = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        EX_R    = ev(2, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        WB_R    = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        EX_LS   = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        MEM_LW  = ev(3, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        WB_LW   = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        MEM_SW  = ev(3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        BEQ_T   = ev(2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        BEQ_N   = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        EX_ADDI = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        EX_SLTI = ev(2, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        WB_I    = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        TRAPV   = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        RST3    = ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        cyc(1, 1, 0, 0, Z0, 0, Z0, "rst_a");
        cyc2(1, 1, 0, Z0, "rst_state");

        opcode = 6'h00; funct = 6'h20;
        cyc2(0, 1, 0, F1, "add_fetch");
        cyc2(0, 1, 0, DD, "add_dec");
        cyc2(0, 1, 0, EX_R, "add_exec");
        cyc2(0, 1, 0, WB_R, "add_wb");

        opcode = 6'h23; funct = 6'h00;
        cyc2(0, 1, 0, F1, "lw_fetch");
        cyc2(0, 1, 0, DD, "lw_dec");
        cyc2(0, 1, 0, EX_LS, "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc2(0, 0, 0, MEM_LW, "lw_mem_stall");
        cyc2(0, 1, 0, MEM_LW, "lw_mem_rdy");
        cyc2(0, 1, 0, WB_LW, "lw_wb");

        opcode = 6'h04;
        cyc2(0, 1, 1, F1, "beqt_fetch");
        cyc2(0, 1, 1, DD, "beqt_dec");
        cyc2(0, 1, 1, BEQ_T, "beqt_exec");
        cyc2(0, 1, 0, F1, "beqn_fetch");
        cyc2(0, 1, 0, DD, "beqn_dec");
        cyc2(0, 1, 0, BEQ_N, "beqn_exec");

        opcode = 6'h02;
        cyc2(0, 1, 0, F1, "j_fetch");
        cyc2(0, 1, 0, DJ, "j_dec");

        opcode = 6'h08;
        cyc2(0, 1, 0, F1, "addi_fetch");
        cyc2(0, 1, 0, DD, "addi_dec");
        cyc2(0, 1, 0, EX_ADDI, "addi_exec");
        cyc2(0, 1, 0, WB_I, "addi_wb");

        opcode = 6'h0A;
        cyc2(0, 1, 0, F1, "slti_fetch");
        cyc2(0, 1, 0, DD, "slti_dec");
        cyc2(0, 1, 0, EX_SLTI, "slti_exec");
        cyc2(0, 1, 0, WB_I, "slti_wb");

        opcode = 6'h3F;
        cyc2(0, 1, 0, F1, "ill_fetch");
        cyc(0, 1, 0, 1, DNOP, 1, DD, "ill_dec");
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 1, (TMO && i >= 16) ? TRAPV : F0,
                1, TRAPV, "ill_hold");
        cyc(1, 0, 0, 0, Z0, 0, Z0, "ill_rst");

        opcode = 6'h2B;
        cyc2(0, 1, 0, F1, "sw_fetch");
        cyc2(0, 1, 0, DD, "sw_dec");
        cyc2(0, 1, 0, EX_LS, "sw_exec");
        cyc2(0, 0, 0, MEM_SW, "sw_mem");
        cyc2(1, 0, 0, RST3, "sw_rst_mem");
        cyc2(0, 0, 0, F0, "sw_after_rst");
        cyc(1, 0, 0, 0, Z0, 0, Z0, "pre_wait_rst");

        if (TMO) begin
            for (int i = 0; i < 16; i++)
                cyc2(0, 0, 0, F0, "to_wait");
            cyc2(0, 0, 0, TRAPV, "to_trap");
            cyc(1, 0, 0, 0, Z0, 0, Z0, "to_rst");
            for (int i = 0; i < 15; i++)
                cyc2(0, 0, 0, F0, "to_wait2");
            cyc2(0, 1, 0, F1, "to_ready_last");
            cyc2(0, 1, 0, DD, "to_dec");
        end else begin
            for (int i = 0; i < 20; i++)
                cyc2(0, 0, 0, F0, "nto_wait");
            cyc2(0, 1, 0, F1, "nto_ready");
            cyc2(0, 1, 0, DD, "nto_dec");
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
